// File: rtl/swizzle_writeback.sv
// Destination swizzle and masked commit of a 3-component result into the
// vector register file. One request in flight; partial writes go through a
// read-modify-write, full writes go straight to the write port.
module swizzle_writeback #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [ADDR_W-1:0] iDestAddr,
  input  logic [2:0]        iDeswizzle,
  input  logic [2:0]        iWriteMask,
  input  logic [WIDTH-1:0]  iResult_X,
  input  logic [WIDTH-1:0]  iResult_Y,
  input  logic [WIDTH-1:0]  iResult_Z,
  output logic              oRF_ReadEnable,
  output logic [ADDR_W-1:0] oRF_ReadAddr,
  input  logic [WIDTH-1:0]  iRF_Data_X,
  input  logic [WIDTH-1:0]  iRF_Data_Y,
  input  logic [WIDTH-1:0]  iRF_Data_Z,
  output logic              oRF_WriteEnable,
  output logic [ADDR_W-1:0] oRF_WriteAddr,
  output logic [WIDTH-1:0]  oRF_Data_X,
  output logic [WIDTH-1:0]  oRF_Data_Y,
  output logic [WIDTH-1:0]  oRF_Data_Z,
  output logic              oDone,
  output logic              oError
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_CAP = 3'd2,
    S_WR     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_ready;
  logic              r_rd_en;
  logic              r_wr_en;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WIDTH-1:0]  r_wdata_x;
  logic [WIDTH-1:0]  r_wdata_y;
  logic [WIDTH-1:0]  r_wdata_z;

  // Request context held for the read-modify-write path
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_emask;
  logic [WIDTH-1:0]  r_d_x;
  logic [WIDTH-1:0]  r_d_y;
  logic [WIDTH-1:0]  r_d_z;

  logic              w_accept;
  logic              w_illegal;
  logic [2:0]        w_m;
  logic [2:0]        w_e;
  logic [WIDTH-1:0]  w_d_x;
  logic [WIDTH-1:0]  w_d_y;
  logic [WIDTH-1:0]  w_d_z;
  logic [WIDTH-1:0]  w_mrg_x;
  logic [WIDTH-1:0]  w_mrg_y;
  logic [WIDTH-1:0]  w_mrg_z;

  assign w_accept = iValid && (r_state == S_IDLE);
  assign w_e      = iWriteMask & w_m;

  // Deswizzle the incoming result; components outside the op mask are don't-care
  always_comb begin
    w_d_x     = '0;
    w_d_y     = '0;
    w_d_z     = '0;
    w_m       = 3'b000;
    w_illegal = 1'b0;
    case (iDeswizzle)
      3'd0: begin w_d_x = iResult_X; w_d_y = iResult_Y; w_d_z = iResult_Z; w_m = 3'b111; end
      3'd1: begin w_d_x = iResult_Y; w_d_y = iResult_X; w_d_z = iResult_Z; w_m = 3'b111; end
      3'd2: begin w_d_x = iResult_X; w_m = 3'b001; end
      3'd3: begin w_d_y = iResult_Y; w_m = 3'b010; end
      3'd4: begin w_d_z = iResult_Z; w_m = 3'b100; end
      3'd5: begin w_d_x = iResult_X; w_d_y = iResult_X; w_d_z = iResult_X; w_m = 3'b111; end
      default: w_illegal = 1'b1;
    endcase
  end

  // Merge new components over the read-back register contents
  always_comb begin
    w_mrg_x = r_emask[0] ? r_d_x : iRF_Data_X;
    w_mrg_y = r_emask[1] ? r_d_y : iRF_Data_Y;
    w_mrg_z = r_emask[2] ? r_d_z : iRF_Data_Z;
  end

  // Next-state decision
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iValid) begin
          if (w_illegal || (w_e == 3'b000)) w_next = S_DONE;
          else if (w_e == 3'b111)           w_next = S_WR;
          else                              w_next = S_RD_REQ;
        end
      end
      S_RD_REQ: w_next = S_RD_CAP;
      S_RD_CAP: w_next = S_WR;
      S_WR:     w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State, registered outputs and request context; strobes follow the next state
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b1;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wdata_x <= '0;
      r_wdata_y <= '0;
      r_wdata_z <= '0;
      r_addr    <= '0;
      r_emask   <= '0;
      r_d_x     <= '0;
      r_d_y     <= '0;
      r_d_z     <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      r_rd_en <= (w_next == S_RD_REQ);
      r_wr_en <= (w_next == S_WR);
      r_done  <= (w_next == S_DONE);
      r_error <= w_accept && w_illegal;
      if (w_accept) begin
        r_addr  <= iDestAddr;
        r_emask <= w_e;
        r_d_x   <= w_d_x;
        r_d_y   <= w_d_y;
        r_d_z   <= w_d_z;
      end
      if (w_accept && (w_next == S_RD_REQ)) r_rd_addr <= iDestAddr;
      if (w_next == S_WR) r_wr_addr <= w_accept ? iDestAddr : r_addr;
      if (w_accept && (w_next == S_WR)) begin
        r_wdata_x <= w_d_x;
        r_wdata_y <= w_d_y;
        r_wdata_z <= w_d_z;
      end else if (r_state == S_RD_CAP) begin
        r_wdata_x <= w_mrg_x;
        r_wdata_y <= w_mrg_y;
        r_wdata_z <= w_mrg_z;
      end
    end
  end

  assign oReady          = r_ready;
  assign oRF_ReadEnable  = r_rd_en;
  assign oRF_ReadAddr    = r_rd_addr;
  assign oRF_WriteEnable = r_wr_en;
  assign oRF_WriteAddr   = r_wr_addr;
  assign oRF_Data_X      = r_wdata_x;
  assign oRF_Data_Y      = r_wdata_y;
  assign oRF_Data_Z      = r_wdata_z;
  assign oDone           = r_done;
  assign oError          = r_error;

endmodule

// File: tb/tb_swizzle_writeback.sv
// Testbench for swizzle_writeback: directed scenarios plus a randomized
// back-to-back run against a register-file reference model.
module tb_swizzle_writeback;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iValid;
  logic        oReady;
  logic [6:0]  iDestAddr;
  logic [2:0]  iDeswizzle;
  logic [2:0]  iWriteMask;
  logic [31:0] iResult_X, iResult_Y, iResult_Z;
  logic        oRF_ReadEnable;
  logic [6:0]  oRF_ReadAddr;
  logic [31:0] iRF_Data_X, iRF_Data_Y, iRF_Data_Z;
  logic        oRF_WriteEnable;
  logic [6:0]  oRF_WriteAddr;
  logic [31:0] oRF_Data_X, oRF_Data_Y, oRF_Data_Z;
  logic        oDone;
  logic        oError;

  int n_checks = 0;
  int n_fail   = 0;

  // Register file contents (the bench plays the register file)
  logic [31:0] rf_x [0:127];
  logic [31:0] rf_y [0:127];
  logic [31:0] rf_z [0:127];

  // Observations of the last transaction
  int          obs_rd_cnt, obs_rd_cyc, obs_wr_cnt, obs_wr_cyc;
  int          obs_done_cnt, obs_done_cyc, obs_err_cnt;
  logic [6:0]  obs_rd_addr, obs_wr_addr, obs_hold_addr;
  logic [31:0] obs_wx, obs_wy, obs_wz, obs_hx, obs_hy, obs_hz;
  bit          obs_err_at_done, obs_busy_ready, obs_ready_after, obs_ready_start;

  swizzle_writeback dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .oReady(oReady),
    .iDestAddr(iDestAddr), .iDeswizzle(iDeswizzle), .iWriteMask(iWriteMask),
    .iResult_X(iResult_X), .iResult_Y(iResult_Y), .iResult_Z(iResult_Z),
    .oRF_ReadEnable(oRF_ReadEnable), .oRF_ReadAddr(oRF_ReadAddr),
    .iRF_Data_X(iRF_Data_X), .iRF_Data_Y(iRF_Data_Y), .iRF_Data_Z(iRF_Data_Z),
    .oRF_WriteEnable(oRF_WriteEnable), .oRF_WriteAddr(oRF_WriteAddr),
    .oRF_Data_X(oRF_Data_X), .oRF_Data_Y(oRF_Data_Y), .oRF_Data_Z(oRF_Data_Z),
    .oDone(oDone), .oError(oError)
  );

  always #5 Clock = ~Clock;

  // Reference model: expected outcome of one request given current RF contents
  task automatic predict(input logic [6:0] a, input logic [2:0] c, input logic [2:0] m,
                         input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz,
                         output bit ex_err, output bit ex_rd, output bit ex_wr, output int ex_done,
                         output logic [31:0] ex_x, output logic [31:0] ex_y, output logic [31:0] ex_z);
    logic [31:0] d [3];
    logic [31:0] old [3];
    logic [31:0] res [3];
    logic [2:0]  opm;
    logic [2:0]  e;
    d   = '{32'd0, 32'd0, 32'd0};
    opm = 3'b000;
    ex_err = 1'b0;
    case (c)
      3'd0: begin d = '{rx, ry, rz}; opm = 3'b111; end
      3'd1: begin d = '{ry, rx, rz}; opm = 3'b111; end
      3'd2: begin d[0] = rx; opm = 3'b001; end
      3'd3: begin d[1] = ry; opm = 3'b010; end
      3'd4: begin d[2] = rz; opm = 3'b100; end
      3'd5: begin d = '{rx, rx, rx}; opm = 3'b111; end
      default: ex_err = 1'b1;
    endcase
    e     = m & opm;
    ex_wr = !ex_err && (e != 3'b000);
    ex_rd = ex_wr && (e != 3'b111);
    if (!ex_wr) ex_done = 1;
    else if (!ex_rd) ex_done = 2;
    else ex_done = 4;
    old = '{rf_x[a], rf_y[a], rf_z[a]};
    for (int i = 0; i < 3; i++) res[i] = e[i] ? d[i] : old[i];
    ex_x = res[0];
    ex_y = res[1];
    ex_z = res[2];
  endtask

  // Drive one request and act as the register file; records what the DUT did
  task automatic exec_txn(input logic [6:0] a, input logic [2:0] c, input logic [2:0] m,
                          input logic [31:0] rx, input logic [31:0] ry, input logic [31:0] rz);
    int   w;
    bit   pend;
    logic [6:0] paddr;
    obs_rd_cnt = 0; obs_rd_cyc = -1; obs_wr_cnt = 0; obs_wr_cyc = -1;
    obs_done_cnt = 0; obs_done_cyc = -1; obs_err_cnt = 0;
    obs_err_at_done = 0; obs_busy_ready = 0; obs_ready_after = 0;
    obs_rd_addr = '0; obs_wr_addr = '0; obs_hold_addr = '0;
    obs_wx = '0; obs_wy = '0; obs_wz = '0; obs_hx = '0; obs_hy = '0; obs_hz = '0;
    w = 0;
    while (!oReady && w < 10) begin
      @(posedge Clock); #1;
      w++;
    end
    obs_ready_start = oReady;
    iValid = 1'b1; iDestAddr = a; iDeswizzle = c; iWriteMask = m;
    iResult_X = rx; iResult_Y = ry; iResult_Z = rz;
    @(posedge Clock); #1;
    pend = 0; paddr = '0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (pend) begin
        iRF_Data_X = rf_x[paddr]; iRF_Data_Y = rf_y[paddr]; iRF_Data_Z = rf_z[paddr];
      end else begin
        iRF_Data_X = $urandom; iRF_Data_Y = $urandom; iRF_Data_Z = $urandom;
      end
      pend = 0;
      if (oRF_ReadEnable) begin
        obs_rd_cnt++; obs_rd_cyc = cyc; obs_rd_addr = oRF_ReadAddr;
        pend = 1; paddr = oRF_ReadAddr;
      end
      if (oRF_WriteEnable) begin
        obs_wr_cnt++; obs_wr_cyc = cyc; obs_wr_addr = oRF_WriteAddr;
        obs_wx = oRF_Data_X; obs_wy = oRF_Data_Y; obs_wz = oRF_Data_Z;
        rf_x[oRF_WriteAddr] = oRF_Data_X;
        rf_y[oRF_WriteAddr] = oRF_Data_Y;
        rf_z[oRF_WriteAddr] = oRF_Data_Z;
      end
      if (oError) obs_err_cnt++;
      if (obs_done_cyc > 0 && cyc == obs_done_cyc + 1) begin
        obs_ready_after = oReady;
        break;
      end
      if (oReady) obs_busy_ready = 1;
      if (oDone) begin
        obs_done_cnt++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = cyc; obs_err_at_done = oError;
          obs_hold_addr = oRF_WriteAddr;
          obs_hx = oRF_Data_X; obs_hy = oRF_Data_Y; obs_hz = oRF_Data_Z;
        end
      end
      if (obs_done_cyc > 0) iValid = 1'b0;
      else begin
        // Busy period: iValid stays high with junk, which must be ignored
        iValid = 1'b1;
        iDestAddr = 7'($urandom); iDeswizzle = 3'($urandom); iWriteMask = 3'($urandom);
        iResult_X = $urandom; iResult_Y = $urandom; iResult_Z = $urandom;
      end
      @(posedge Clock); #1;
    end
    iValid = 1'b0;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    @(posedge Clock); #1;
    n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", oReady); end
    n_checks++; if ({oRF_ReadEnable, oRF_WriteEnable, oDone, oError} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {oRF_ReadEnable, oRF_WriteEnable, oDone, oError}); end
    n_checks++; if ({oRF_ReadAddr, oRF_WriteAddr, oRF_Data_X, oRF_Data_Y, oRF_Data_Z} !== '0) begin
      n_fail++; $display("FAIL reset_data: got addr %h/%h data %h %h %h expected all 0",
                         oRF_ReadAddr, oRF_WriteAddr, oRF_Data_X, oRF_Data_Y, oRF_Data_Z); end
    Reset = 1'b0;
    @(posedge Clock); #1;
  endtask

  task automatic test_reset_mid_txn;
    int wr_seen, rd_seen;
    // Leave a written value on the data outputs so the reset clearing is visible
    exec_txn(7'd9, 3'd0, 3'b111, 32'hDEAD, 32'hBEEF, 32'hCAFE);
    rf_x[3] = 32'h10; rf_y[3] = 32'h20; rf_z[3] = 32'h30;
    iValid = 1'b1; iDestAddr = 7'd3; iDeswizzle = 3'd3; iWriteMask = 3'b111;
    iResult_X = 32'd7; iResult_Y = 32'd8; iResult_Z = 32'd9;
    @(posedge Clock); #1;          // cycle 1: RD_REQ
    iValid = 1'b0;
    @(posedge Clock); #1;          // cycle 2: RD_CAP
    iRF_Data_X = 32'h10; iRF_Data_Y = 32'h20; iRF_Data_Z = 32'h30;
    Reset = 1'b1;
    #1;
    n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", oReady); end
    n_checks++; if ({oRF_ReadEnable, oRF_WriteEnable, oDone, oError} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_strobes: got %b expected 0000", {oRF_ReadEnable, oRF_WriteEnable, oDone, oError}); end
    n_checks++; if ({oRF_ReadAddr, oRF_WriteAddr, oRF_Data_X, oRF_Data_Y, oRF_Data_Z} !== '0) begin
      n_fail++; $display("FAIL midrst_data: got addr %h/%h data %h %h %h expected all 0",
                         oRF_ReadAddr, oRF_WriteAddr, oRF_Data_X, oRF_Data_Y, oRF_Data_Z); end
    @(posedge Clock); #1;
    Reset = 1'b0;
    wr_seen = 0; rd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clock); #1;
      if (oRF_WriteEnable) wr_seen++;
      if (oRF_ReadEnable || oDone) rd_seen++;
    end
    n_checks++; if (wr_seen !== 0) begin n_fail++; $display("FAIL midrst_no_write: got %0d writes expected 0", wr_seen); end
    n_checks++; if (rd_seen !== 0) begin n_fail++; $display("FAIL midrst_no_other: got %0d read/done pulses expected 0", rd_seen); end
    n_checks++; if (oReady !== 1'b1) begin n_fail++; $display("FAIL midrst_ready_after: got %b expected 1", oReady); end
  endtask

  task automatic test_full_write;
    exec_txn(7'd5, 3'd0, 3'b111, 32'd1, 32'd2, 32'd3);
    n_checks++; if (obs_rd_cnt !== 0) begin n_fail++; $display("FAIL pass_no_read: got %0d reads expected 0", obs_rd_cnt); end
    n_checks++; if (obs_wr_cnt !== 1 || obs_wr_cyc !== 1) begin
      n_fail++; $display("FAIL pass_wr_cycle: got %0d writes at cycle %0d expected 1 at cycle 1", obs_wr_cnt, obs_wr_cyc); end
    n_checks++; if (obs_wr_addr !== 7'd5 || {obs_wx, obs_wy, obs_wz} !== {32'd1, 32'd2, 32'd3}) begin
      n_fail++; $display("FAIL pass_wr_data: got addr %0d data %h %h %h expected addr 5 data 1 2 3", obs_wr_addr, obs_wx, obs_wy, obs_wz); end
    n_checks++; if (obs_done_cyc !== 2 || obs_err_at_done !== 1'b0) begin
      n_fail++; $display("FAIL pass_done: got cycle %0d err %b expected cycle 2 err 0", obs_done_cyc, obs_err_at_done); end
    exec_txn(7'd6, 3'd1, 3'b111, 32'hA, 32'hB, 32'hC);
    n_checks++; if (obs_wr_cyc !== 1 || {obs_wx, obs_wy, obs_wz} !== {32'hB, 32'hA, 32'hC}) begin
      n_fail++; $display("FAIL swap_wr_data: got cycle %0d data %h %h %h expected cycle 1 data b a c", obs_wr_cyc, obs_wx, obs_wy, obs_wz); end
    n_checks++; if ({obs_hx, obs_hy, obs_hz} !== {32'hB, 32'hA, 32'hC} || obs_hold_addr !== 7'd6) begin
      n_fail++; $display("FAIL swap_hold: got addr %0d data %h %h %h expected addr 6 data b a c held", obs_hold_addr, obs_hx, obs_hy, obs_hz); end
  endtask

  task automatic test_partial_write;
    rf_x[3] = 32'h10; rf_y[3] = 32'h20; rf_z[3] = 32'h30;
    exec_txn(7'd3, 3'd3, 3'b111, 32'd7, 32'd8, 32'd9);
    n_checks++; if (obs_rd_cnt !== 1 || obs_rd_cyc !== 1 || obs_rd_addr !== 7'd3) begin
      n_fail++; $display("FAIL yonly_read: got %0d reads cycle %0d addr %0d expected 1 at cycle 1 addr 3", obs_rd_cnt, obs_rd_cyc, obs_rd_addr); end
    n_checks++; if (obs_wr_cyc !== 3 || {obs_wx, obs_wy, obs_wz} !== {32'h10, 32'd8, 32'h30}) begin
      n_fail++; $display("FAIL yonly_write: got cycle %0d data %h %h %h expected cycle 3 data 10 8 30", obs_wr_cyc, obs_wx, obs_wy, obs_wz); end
    n_checks++; if (obs_done_cyc !== 4) begin n_fail++; $display("FAIL yonly_done: got cycle %0d expected 4", obs_done_cyc); end
    rf_x[2] = 32'd1; rf_y[2] = 32'd2; rf_z[2] = 32'd3;
    exec_txn(7'd2, 3'd5, 3'b101, 32'h55, 32'h66, 32'h77);
    n_checks++; if (obs_wr_addr !== 7'd2 || {obs_wx, obs_wy, obs_wz} !== {32'h55, 32'd2, 32'h55}) begin
      n_fail++; $display("FAIL bcast_write: got addr %0d data %h %h %h expected addr 2 data 55 2 55", obs_wr_addr, obs_wx, obs_wy, obs_wz); end
  endtask

  task automatic test_no_access;
    exec_txn(7'd4, 3'd6, 3'b111, 32'd1, 32'd2, 32'd3);
    n_checks++; if (obs_done_cyc !== 1 || obs_err_at_done !== 1'b1 || obs_err_cnt !== 1) begin
      n_fail++; $display("FAIL illegal_done: got cycle %0d err %b pulses %0d expected cycle 1 err 1 pulses 1", obs_done_cyc, obs_err_at_done, obs_err_cnt); end
    n_checks++; if (obs_rd_cnt + obs_wr_cnt !== 0) begin
      n_fail++; $display("FAIL illegal_no_rf: got %0d strobes expected 0", obs_rd_cnt + obs_wr_cnt); end
    exec_txn(7'd4, 3'd2, 3'b010, 32'd1, 32'd2, 32'd3);
    n_checks++; if (obs_done_cyc !== 1 || obs_err_cnt !== 0) begin
      n_fail++; $display("FAIL emask0_done: got cycle %0d err pulses %0d expected cycle 1 err 0", obs_done_cyc, obs_err_cnt); end
    n_checks++; if (obs_rd_cnt + obs_wr_cnt !== 0) begin
      n_fail++; $display("FAIL emask0_no_rf: got %0d strobes expected 0", obs_rd_cnt + obs_wr_cnt); end
  endtask

  task automatic test_back_to_back;
    bit ex_err, ex_rd, ex_wr;
    int ex_done;
    logic [31:0] ex_x, ex_y, ex_z;
    logic [6:0]  a;
    logic [2:0]  c, m;
    logic [31:0] rx, ry, rz;
    for (int t = 0; t < 150; t++) begin
      a = 7'($urandom_range(15, 0)); c = 3'($urandom); m = 3'($urandom);
      rx = $urandom; ry = $urandom; rz = $urandom;
      predict(a, c, m, rx, ry, rz, ex_err, ex_rd, ex_wr, ex_done, ex_x, ex_y, ex_z);
      exec_txn(a, c, m, rx, ry, rz);
      n_checks++; if (obs_ready_start !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_start[%0d]: got %b expected 1", t, obs_ready_start); end
      n_checks++; if (obs_done_cyc !== ex_done || obs_done_cnt !== 1) begin
        n_fail++; $display("FAIL b2b_done[%0d]: got cycle %0d count %0d expected cycle %0d count 1", t, obs_done_cyc, obs_done_cnt, ex_done); end
      n_checks++; if (obs_err_at_done !== ex_err || obs_err_cnt !== int'(ex_err)) begin
        n_fail++; $display("FAIL b2b_error[%0d]: got %b pulses %0d expected %b", t, obs_err_at_done, obs_err_cnt, ex_err); end
      n_checks++; if (obs_rd_cnt !== int'(ex_rd) || (ex_rd && (obs_rd_cyc !== 1 || obs_rd_addr !== a))) begin
        n_fail++; $display("FAIL b2b_read[%0d]: got %0d reads cycle %0d addr %0d expected %0d reads addr %0d", t, obs_rd_cnt, obs_rd_cyc, obs_rd_addr, ex_rd, a); end
      n_checks++; if (obs_wr_cnt !== int'(ex_wr) || (ex_wr && (obs_wr_cyc !== ex_done - 1 || obs_wr_addr !== a))) begin
        n_fail++; $display("FAIL b2b_write[%0d]: got %0d writes cycle %0d addr %0d expected %0d writes cycle %0d addr %0d", t, obs_wr_cnt, obs_wr_cyc, obs_wr_addr, ex_wr, ex_done - 1, a); end
      if (ex_wr) begin
        n_checks++; if ({obs_wx, obs_wy, obs_wz} !== {ex_x, ex_y, ex_z}) begin
          n_fail++; $display("FAIL b2b_wdata[%0d]: got %h %h %h expected %h %h %h", t, obs_wx, obs_wy, obs_wz, ex_x, ex_y, ex_z); end
      end
      n_checks++; if (obs_busy_ready !== 1'b0 || obs_ready_after !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got busy %b after %b expected busy 0 after 1", t, obs_busy_ready, obs_ready_after); end
    end
  endtask

  initial begin
    iValid = 1'b0; iDestAddr = '0; iDeswizzle = '0; iWriteMask = '0;
    iResult_X = '0; iResult_Y = '0; iResult_Z = '0;
    iRF_Data_X = '0; iRF_Data_Y = '0; iRF_Data_Z = '0;
    for (int i = 0; i < 128; i++) begin
      rf_x[i] = $urandom; rf_y[i] = $urandom; rf_z[i] = $urandom;
    end
    test_reset();
    test_full_write();
    test_partial_write();
    test_no_access();
    test_reset_mid_txn();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/swizzle_writeback.md
Name: swizzle_writeback

Overview:
- Destination-side counterpart of the source swizzle stage: takes a 3-component execution result, applies the inverse (destination) swizzle and a per-component write mask, then commits it to the vector register file.
- Partial writes are done as read-modify-write through the register-file port. Full writes skip the read.
- Sits between the execution unit result bus and the register file write port; one request in flight at a time.

Parameters:
WIDTH, 32, width of one vector component
ADDR_W, 7, register-file address width

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
iValid  in  1  request valid
oReady  out  1  block can accept a request (high only in IDLE)
iDestAddr  in  ADDR_W  destination register address
iDeswizzle  in  3  destination swizzle code
iWriteMask  in  3  component enables, bit0=X bit1=Y bit2=Z
iResult_X / iResult_Y / iResult_Z  in  WIDTH each  execution result
oRF_ReadEnable  out  1  register-file read strobe
oRF_ReadAddr  out  ADDR_W  read address
iRF_Data_X / iRF_Data_Y / iRF_Data_Z  in  WIDTH each  read data, valid exactly 1 cycle after oRF_ReadEnable
oRF_WriteEnable  out  1  register-file write strobe
oRF_WriteAddr  out  ADDR_W  write address
oRF_Data_X / oRF_Data_Y / oRF_Data_Z  out  WIDTH each  write data
oDone  out  1  one-cycle completion pulse
oError  out  1  one-cycle pulse with oDone for an illegal iDeswizzle code

Behaviour:
- Reset (async, any state): state=IDLE, internal registers cleared.
  - All outputs 0 except oReady=1.
  - A request in flight is dropped; no read or write strobe follows.
- Accept: a request is accepted when iValid and oReady are both high. On acceptance, latch address, code, mask and the three results. Inputs are ignored at all other times.
- Deswizzle on the latched results R, giving vector D and op mask M:
  - 0 PASS: D=(R.X,R.Y,R.Z), M=111
  - 1 SWAP_YXZ: D=(R.Y,R.X,R.Z), M=111
  - 2 X_ONLY: D.X=R.X, M=001
  - 3 Y_ONLY: D.Y=R.Y, M=010
  - 4 Z_ONLY: D.Z=R.Z, M=100
  - 5 BCAST_X: D=(R.X,R.X,R.X), M=111
  - 6, 7: illegal
- Effective mask E = iWriteMask & M, computed at acceptance.
- States: IDLE, RD_REQ, RD_CAP, WR, DONE.
- IDLE, on accept:
  - illegal code -> DONE with error flag set
  - E=000 -> DONE (no register-file access)
  - E=111 -> WR
  - otherwise -> RD_REQ
- RD_REQ: oRF_ReadEnable=1, oRF_ReadAddr=latched address, for one cycle -> RD_CAP.
- RD_CAP: capture iRF_Data_*; merged component = D where the E bit is 1, else the read-back value -> WR.
- WR: one cycle with oRF_WriteEnable=1, oRF_WriteAddr=latched address.
  - Full write: data is D.
  - Partial write: data is the merged vector.
  - -> DONE.
- DONE: oDone=1 for one cycle; oError=1 in the same cycle if the code was illegal -> IDLE.
- Outputs are registered. Address and data outputs hold their values while their strobe is low; only the strobes are qualified.
- Latency from the accept cycle (cycle 0):
  - full write: WR in cycle 1, oDone in cycle 2
  - partial write: RD_REQ 1, RD_CAP 2, WR 3, oDone 4
  - E=000 or illegal: oDone in cycle 1
- Back-to-back: oReady is high again in the cycle after DONE. Throughput is at most one request per 3 cycles (full) or per 5 cycles (partial).
- iValid held high while oReady is low: no effect, no queuing.
- No arithmetic; components pass through bit-exact.

Test Plan:
- Reset asserted mid-transaction, in RD_CAP of a partial write -> no oRF_WriteEnable ever; oReady=1 immediately; all other outputs 0.
- PASS, mask 111, R=(1,2,3), addr 5 -> no read; write in cycle 1 of addr 5 with data (1,2,3); oDone in cycle 2.
- SWAP_YXZ, mask 111, R=(0xA,0xB,0xC) -> write data (0xB,0xA,0xC).
- Y_ONLY, mask 111, R=(7,8,9), RF[3]=(0x10,0x20,0x30) -> read in cycle 1; write (0x10,8,0x30) in cycle 3; oDone in cycle 4.
- BCAST_X, mask 101, R=(0x55,x,x), RF[2]=(1,2,3) -> write (0x55,2,0x55).
- Code 6 -> oDone and oError together in cycle 1, no RF strobes. Then X_ONLY with mask 010 (E=000) -> oDone in cycle 1, oError=0, no RF strobes.
